// File: rtl/as_pkg.sv
// Shared types and constants for the add/sub result capture path.
package as_pkg;

  localparam int AS_DW = 4;

  // Saturation targets for an AS_DW-bit two's-complement result
  localparam logic [AS_DW-1:0] AS_SAT_POS = {1'b0, {(AS_DW-1){1'b1}}};
  localparam logic [AS_DW-1:0] AS_SAT_NEG = {1'b1, {(AS_DW-1){1'b0}}};

  typedef struct packed {
    logic             sel;
    logic             ovf;
    logic [AS_DW-1:0] data;
  } as_result_t;

endpackage

// File: rtl/as_result_fifo_if.sv
// Upstream/downstream handshake bundle for as_result_fifo.
// slave = FIFO view, master = producer/consumer view.
interface as_result_fifo_if
  import as_pkg::*;
#(
  parameter int DW = AS_DW
);
  logic          in_valid;
  logic          in_ready;
  logic          in_sel;
  logic [DW-1:0] in_s;
  logic          in_o;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_ovf;
  logic          out_sel;

  modport slave (
    input  in_valid, in_sel, in_s, in_o, out_ready,
    output in_ready, out_valid, out_data, out_ovf, out_sel
  );

  modport master (
    output in_valid, in_sel, in_s, in_o, out_ready,
    input  in_ready, out_valid, out_data, out_ovf, out_sel
  );
endinterface

// File: rtl/as_sat_unit.sv
// Clamps an overflowed result to the signed rail when AS_RESULT_SATURATE_EN is
// defined; otherwise a pure pass-through of the wrapped value.
module as_sat_unit
  import as_pkg::*;
#(
  parameter int DW = AS_DW
) (
  input  logic [DW-1:0] data_in,
  input  logic          ovf,
  output logic [DW-1:0] data_out
);

`ifdef AS_RESULT_SATURATE_EN
  // A wrapped negative sign means the true result overshot positive, and vice versa
  always_comb begin
    data_out = data_in;
    if (ovf) data_out = data_in[DW-1] ? AS_SAT_POS : AS_SAT_NEG;
  end
`else
  logic unused_ovf;
  assign unused_ovf = ovf;
  assign data_out   = data_in;
`endif

endmodule

// File: rtl/as_result_fifo.sv
// Show-ahead result FIFO with sticky/counting overflow status.
// Optional AS_RESULT_SATURATE_EN clamps overflowed results on write.
module as_result_fifo
  import as_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int DW    = AS_DW,
  parameter int CNT_W = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  as_result_fifo_if.slave        bus,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty,
  input  logic                   ovf_clr,
  output logic                   ovf_sticky,
  output logic [CNT_W-1:0]       ovf_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  as_result_t    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push;
  logic          pop;
  logic [DW-1:0] wr_data;
  as_result_t    head;

  as_sat_unit #(.DW(DW)) u_sat (
    .data_in  (bus.in_s),
    .ovf      (bus.in_o),
    .data_out (wr_data)
  );

  // Status comes only from registered count, so in_ready never depends on out_ready
  assign full          = (count == CW'(DEPTH));
  assign empty         = (count == '0);
  assign bus.in_ready  = !full;
  assign bus.out_valid = !empty;
  assign push          = bus.in_valid && !full;
  assign pop           = bus.out_ready && !empty;

  // DEPTH is a power of two, so natural pointer rollover is the modulo wrap
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{sel: bus.in_sel, ovf: bus.in_o, data: wr_data};
  end

  // Storage is not reset, so mask the head while nothing valid is held
  assign head         = empty ? '0 : mem[rd_ptr];
  assign bus.out_data = head.data;
  assign bus.out_ovf  = head.ovf;
  assign bus.out_sel  = head.sel;

  // An overflowed push in the clear cycle counts as the first event after the clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_sticky <= 1'b0;
      ovf_count  <= '0;
    end else if (push && bus.in_o) begin
      ovf_sticky <= 1'b1;
      if (ovf_clr)                    ovf_count <= CNT_W'(1);
      else if (ovf_count != CNT_MAX)  ovf_count <= ovf_count + 1'b1;
    end else if (ovf_clr) begin
      ovf_sticky <= 1'b0;
      ovf_count  <= '0;
    end
  end

endmodule

// File: tb/tb_as_result_fifo.sv
// Scoreboard bench for as_result_fifo; honours AS_RESULT_SATURATE_EN.
`timescale 1ns/1ps
module tb_as_result_fifo;
  import as_pkg::*;

  localparam int DEPTH = 4;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             ovf_clr = 1'b0;
  logic [2:0]       count;
  logic             full;
  logic             empty;
  logic             ovf_sticky;
  logic [CNT_W-1:0] ovf_count;

  as_result_fifo_if bus ();

  as_result_fifo #(.DEPTH(DEPTH), .DW(AS_DW), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .count      (count),
    .full       (full),
    .empty      (empty),
    .ovf_clr    (ovf_clr),
    .ovf_sticky (ovf_sticky),
    .ovf_count  (ovf_count)
  );

  always #5 clk = ~clk;

  int         errors = 0;
  int         checks = 0;
  as_result_t mq[$];
  logic       m_sticky = 1'b0;
  int         m_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [AS_DW-1:0] exp_data(input logic [AS_DW-1:0] s, input logic o);
`ifdef AS_RESULT_SATURATE_EN
    if (o) return s[AS_DW-1] ? 4'b0111 : 4'b1000;
`endif
    return s;
  endfunction

  task automatic drv(input logic v, input logic sel, input logic [3:0] s, input logic o,
                     input logic rdy, input logic clr);
    bus.in_valid  = v;
    bus.in_sel    = sel;
    bus.in_s      = s;
    bus.in_o      = o;
    bus.out_ready = rdy;
    ovf_clr       = clr;
  endtask

  // Compare registered state at negedge, then advance the model on the posedge
  task automatic step();
    as_result_t e;
    logic       m_push;
    logic       m_pop;
    @(negedge clk);
    chk("count", 32'(count), 32'(mq.size()));
    chk("empty", 32'(empty), 32'(mq.size() == 0));
    chk("full", 32'(full), 32'(mq.size() == DEPTH));
    chk("in_ready", 32'(bus.in_ready), 32'(mq.size() != DEPTH));
    chk("out_valid", 32'(bus.out_valid), 32'(mq.size() != 0));
    chk("ovf_sticky", 32'(ovf_sticky), 32'(m_sticky));
    chk("ovf_count", 32'(ovf_count), 32'(m_cnt));
    if (mq.size() > 0) e = mq[0];
    else e = '0;
    chk("out_data", 32'(bus.out_data), 32'(e.data));
    chk("out_ovf", 32'(bus.out_ovf), 32'(e.ovf));
    chk("out_sel", 32'(bus.out_sel), 32'(e.sel));
    @(posedge clk);
    m_push = bus.in_valid && (mq.size() < DEPTH);
    m_pop  = bus.out_ready && (mq.size() > 0);
    if (m_pop) void'(mq.pop_front());
    if (m_push) mq.push_back('{sel: bus.in_sel, ovf: bus.in_o,
                               data: exp_data(bus.in_s, bus.in_o)});
    if (m_push && bus.in_o) begin
      m_sticky = 1'b1;
      m_cnt    = ovf_clr ? 1 : ((m_cnt == 15) ? 15 : m_cnt + 1);
    end else if (ovf_clr) begin
      m_sticky = 1'b0;
      m_cnt    = 0;
    end
    #1;
  endtask

  initial begin
    drv(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    #23;
    rst = 1'b0;
    #3;

    // Fill to full, attempt a 5th push, then drain in order
    for (int i = 1; i <= 4; i++) begin
      drv(1'b1, 1'b0, 4'(i), 1'b0, 1'b0, 1'b0);
      step();
    end
    drv(1'b1, 1'b0, 4'd5, 1'b0, 1'b0, 1'b0);
    step();
    step();
    drv(1'b0, 1'b0, 4'd5, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) step();

    // Continuous streaming through wrapping pointers
    for (int i = 0; i < 10; i++) begin
      drv(1'b1, 1'(i), 4'(i + 6), 1'b0, 1'b1, 1'b0);
      step();
    end
    drv(1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
    step();
    step();

    // Overflow count 1,2,3 then clear coinciding with an overflowed push
    for (int i = 0; i < 3; i++) begin
      drv(1'b1, 1'b0, 4'b1000, 1'b1, 1'b1, 1'b0);
      step();
    end
    drv(1'b1, 1'b0, 4'b1000, 1'b1, 1'b1, 1'b1);
    step();
    drv(1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
    step();
    chk("ovf_after_clr_sticky", 32'(ovf_sticky), 32'd1);
    chk("ovf_after_clr_count", 32'(ovf_count), 32'd1);
    drv(1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b1);
    step();
    drv(1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
    step();

    // Counter saturation
    for (int i = 0; i < 20; i++) begin
      drv(1'b1, 1'(i), 4'(i), 1'b1, 1'b1, 1'b0);
      step();
    end
    drv(1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
    step();
    step();
    chk("ovf_count_sat", 32'(ovf_count), 32'd15);

    // Saturation of stored data
    drv(1'b1, 1'b0, 4'b1001, 1'b1, 1'b0, 1'b0);
    step();
    drv(1'b1, 1'b1, 4'b0110, 1'b1, 1'b0, 1'b0);
    step();
    drv(1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
`ifdef AS_RESULT_SATURATE_EN
    chk("sat_head0", 32'(bus.out_data), 32'h7);
`else
    chk("sat_head0", 32'(bus.out_data), 32'h9);
`endif
    chk("sat_ovf0", 32'(bus.out_ovf), 32'd1);
    @(posedge clk);
    #1;
    void'(mq.pop_front());
    @(negedge clk);
`ifdef AS_RESULT_SATURATE_EN
    chk("sat_head1", 32'(bus.out_data), 32'h8);
`else
    chk("sat_head1", 32'(bus.out_data), 32'h6);
`endif
    chk("sat_ovf1", 32'(bus.out_ovf), 32'd1);
    @(posedge clk);
    #1;
    void'(mq.pop_front());
    step();

    // Randomised traffic
    for (int i = 0; i < 300; i++) begin
      drv(1'($urandom_range(0, 3) != 0), 1'($urandom), 4'($urandom), 1'($urandom_range(0, 3) == 0),
          1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 15) == 0));
      step();
    end

    // Async reset with three entries held
    drv(1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) step();
    for (int i = 0; i < 3; i++) begin
      drv(1'b1, 1'b0, 4'(i + 3), 1'b1, 1'b0, 1'b0);
      step();
    end
    drv(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    step();
    chk("pre_rst_count", 32'(count), 32'd3);
    #1;
    rst = 1'b1;
    #1;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_ovf_count", 32'(ovf_count), 32'd0);
    chk("rst_out_data", 32'(bus.out_data), 32'd0);
    mq.delete();
    m_sticky = 1'b0;
    m_cnt    = 0;
    @(posedge clk);
    #2;
    rst = 1'b0;
    drv(1'b1, 1'b1, 4'hA, 1'b0, 1'b1, 1'b0);
    step();
    drv(1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
    step();
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
